// File: rtl/prbs4_checker.sv
// Receive-side checker for the x^4+x^3+1 PRBS stream: self-synchronises, then free-runs
// a local LFSR and reports lock, per-bit error pulses and saturating error/bit counters.
module prbs4_checker #(
  parameter int LOCK_CNT    = 8,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  typedef enum logic {SEARCH, LOCKED} state_t;

  localparam logic [7:0] LOCK_N   = 8'(LOCK_CNT);
  localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_ERRS);

  state_t           state, state_nx;
  logic [3:0]       sr, sr_nx;
  logic [2:0]       fill, fill_nx;
  logic [7:0]       match_cnt, match_nx;
  logic [7:0]       consec_err, consec_nx;
  logic             err_nx;
  logic [CNT_W-1:0] errc_nx, bitc_nx;
  logic             pred;

  always_comb begin
    state_nx  = state;
    sr_nx     = sr;
    fill_nx   = fill;
    match_nx  = match_cnt;
    consec_nx = consec_err;
    err_nx    = 1'b0;
    errc_nx   = err_count;
    bitc_nx   = bit_count;
    pred      = sr[2] ^ sr[3];

    if (bit_valid) begin
      // Once locked, sr doubles as the local LFSR and shifts in its own prediction.
      sr_nx = {sr[2:0], (state == LOCKED) ? pred : bit_in};
      case (state)
        SEARCH: begin
          if (fill != 3'd4) begin
            fill_nx = fill + 3'd1;
          end else if ((bit_in == pred) && (sr != '0)) begin
            if (match_cnt == LOCK_N - 8'd1) begin
              state_nx  = LOCKED;
              match_nx  = '0;
              consec_nx = '0;
            end else begin
              match_nx = match_cnt + 8'd1;
            end
          end else begin
            match_nx = '0;
          end
        end
        LOCKED: begin
          if (bit_count != '1) bitc_nx = bit_count + CNT_W'(1);
          if (bit_in != pred) begin
            err_nx = 1'b1;
            if (err_count != '1) errc_nx = err_count + CNT_W'(1);
            if (consec_err == UNLOCK_N - 8'd1) begin
              state_nx  = SEARCH;
              fill_nx   = '0;
              match_nx  = '0;
              consec_nx = '0;
            end else begin
              consec_nx = consec_err + 8'd1;
            end
          end else begin
            consec_nx = '0;
          end
        end
        default: state_nx = SEARCH;
      endcase
    end

    if (clear) begin
      errc_nx = '0;
      bitc_nx = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEARCH;
      sr         <= '0;
      fill       <= '0;
      match_cnt  <= '0;
      consec_err <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      bit_count  <= '0;
    end else begin
      state      <= state_nx;
      sr         <= sr_nx;
      fill       <= fill_nx;
      match_cnt  <= match_nx;
      consec_err <= consec_nx;
      locked     <= (state_nx == LOCKED);
      err_pulse  <= err_nx;
      err_count  <= errc_nx;
      bit_count  <= bitc_nx;
    end
  end

endmodule

// File: doc/prbs4_checker.md
Name: prbs4_checker

Overview:
Serial receiver and checker for the 4-bit PRBS stream produced by the team's LFSR generator. The generator uses polynomial x^4+x^3+1, feedback lfsr[2]^lfsr[3], and sends one bit per step.
The checker self-synchronises to the incoming bits, then free-runs a local LFSR and compares each received bit with the predicted bit. It reports lock status, per-bit error pulses and saturating error/bit counters. It sits on the receive side of a loopback or link-test path.

Parameters:
LOCK_CNT, 8, consecutive correct predictions in SEARCH needed to declare lock (1..255)
UNLOCK_ERRS, 4, consecutive mismatches in LOCKED that force return to SEARCH (1..255)
CNT_W, 16, width of err_count and bit_count

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
bit_in  in  1  received serial data bit
bit_valid  in  1  bit_in is a new stream bit this cycle; gaps of any length allowed
clear  in  1  synchronous clear of err_count and bit_count
locked  out  1  checker is synchronised (LOCKED state)
err_pulse  out  1  one-cycle pulse: previous valid beat mismatched while locked
err_count  out  CNT_W  saturating count of mismatches while locked
bit_count  out  CNT_W  saturating count of valid beats processed while locked

Behaviour:
- Stream definition: b[n] = b[n-3] ^ b[n-4]. Shift register sr <= {sr[2:0], bit}, so sr[3] is the oldest bit. Predicted bit = sr[2]^sr[3].
- Reset (rst_n low, async): state=SEARCH, sr=0, fill=0, match_cnt=0, consec_err=0, locked=0, err_pulse=0, err_count=0, bit_count=0.
- Only cycles with bit_valid=1 are beats. Non-beat cycles hold all state, and err_pulse is 0.
- SEARCH state:
  - Every beat shifts bit_in into sr.
  - While fill<4, fill increments and no comparison is made.
  - Once fill==4, each beat compares bit_in with sr[2]^sr[3] from the pre-shift value of sr.
  - A match with sr!=0 increments match_cnt. A mismatch, or sr==0, sets match_cnt=0. This rejects stuck-at-0 lines.
  - When a beat produces the LOCK_CNT-th consecutive match, state becomes LOCKED and locked=1 on the following clock edge. The local LFSR is the post-shift sr.
- LOCKED state:
  - Each beat computes e = lfsr[2]^lfsr[3] and updates lfsr <= {lfsr[2:0], e}. The local LFSR shifts in e, never bit_in, so one line error yields exactly one error.
  - On bit_in != e: err_pulse=1 on the next cycle, err_count increments (saturating at all-ones), consec_err increments.
  - On a match: consec_err=0.
  - Every beat increments bit_count, saturating at all-ones.
- Unlock: when a beat makes consec_err reach UNLOCK_ERRS, the next state is SEARCH with locked=0, fill=0, match_cnt=0, consec_err=0.
  - That beat's error is still counted and pulsed.
  - err_count and bit_count are retained until clear or reset.
- All outputs are registered. Latency from a beat to err_pulse, locked change or counter update is 1 clock.
- clear:
  - Sets err_count=0 and bit_count=0 next cycle, in any state.
  - If clear and a beat occur in the same cycle, clear wins for both counters. The beat still updates lfsr/sr/state, and err_pulse still fires.
- Asserting rst_n low mid-operation returns everything to reset values immediately, without waiting for a clock. Resync is required afterwards.

Test Plan:
- Contiguous generator stream from seed 1111 (0,0,0,1,0,0,1,1,0,1,0,1,1,1,1 repeating), bit_valid=1 every cycle, LOCK_CNT=8 -> locked rises 1 clk after beat 12; err_count=0; after 30 further beats bit_count=30.
- Same stream with bit_valid toggling 1,0,1,0 -> identical lock point counted in beats (beat 12), counters unchanged during gaps.
- Locked, invert one bit -> single err_pulse 1 clk later, err_count=1, locked stays 1; next beats match.
- Locked, invert 4 consecutive bits -> err_count=4, locked falls 1 clk after 4th bad beat; resume clean stream -> relock after 12 more beats; err_count still 4.
- Constant bit_in=0 for 100 beats -> locked never asserts; constant 1 -> mismatches, never locks.
- CNT_W=3, inject 10 isolated errors -> err_count saturates at 7; clear coincident with an erroneous beat -> err_count=0, err_pulse=1; rst_n low mid-lock -> locked=0, counters 0 without a clock edge.
